// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ requesters.
// Latches the winner's byte and parity config, launches the frame, and recovers from a stalled start.
module uart_tx_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int START_TO   = 16
) (
  input  logic                          TX_CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ_V,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]            REQ_PAR_EN,
  input  logic [NUM_REQ-1:0]            REQ_PAR_TYP,
  output logic [NUM_REQ-1:0]            REQ_ACK,
  output logic [DATA_WIDTH-1:0]         TX_IN_P,
  output logic                          TX_IN_V,
  input  logic                          TX_OUT_V,
  output logic                          parity_enable,
  output logic                          parity_type,
  output logic [$clog2(NUM_REQ)-1:0]    GRANT_ID,
  output logic                          SCHED_BUSY,
  output logic                          START_TIMEOUT
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(START_TO + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(START_TO - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD       = 2'd1,
    WAIT_START = 2'd2,
    WAIT_END   = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [IDW-1:0]  rr_ptr_r;
  logic [CW-1:0]   cnt_r;
  logic            win_found_s;
  logic [IDW-1:0]  win_idx_s;
  logic [IDW-1:0]  cand_s;
  logic            grant_s;
  logic            timeout_s;
  logic            frame_done_s;
  logic [IDW-1:0]  ptr_after_s;

  // Round-robin search: first requester with REQ_V set, upward from rr_ptr_r with wrap.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = IDW'((int'(rr_ptr_r) + i) % NUM_REQ);
      if (!win_found_s && REQ_V[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  assign grant_s     = (state_r == IDLE) && win_found_s;
  assign ptr_after_s = (GRANT_ID == IDW'(NUM_REQ - 1)) ? '0 : GRANT_ID + IDW'(1);

  // Next-state logic and the two frame-termination events.
  always_comb begin
    state_nxt_s  = state_r;
    timeout_s    = 1'b0;
    frame_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (win_found_s) begin
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        state_nxt_s = WAIT_START;
      end
      WAIT_START: begin
        if (TX_OUT_V) begin
          state_nxt_s = WAIT_END;
        end else if (cnt_r == TO_LAST) begin
          state_nxt_s = IDLE;
          timeout_s   = 1'b1;
        end else begin
          state_nxt_s = WAIT_START;
        end
      end
      WAIT_END: begin
        if (!TX_OUT_V) begin
          state_nxt_s  = IDLE;
          frame_done_s = 1'b1;
        end else begin
          state_nxt_s = WAIT_END;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, start-wait counter and round-robin pointer.
  always_ff @(posedge TX_CLK or negedge RST) begin
    if (!RST) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      rr_ptr_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == WAIT_START) && !TX_OUT_V) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= '0;
      end
      // A timed-out request counts as consumed, so the pointer moves on either way.
      if (timeout_s || frame_done_s) begin
        rr_ptr_r <= ptr_after_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  // Registered strobes and the per-frame latched byte/config.
  always_ff @(posedge TX_CLK or negedge RST) begin
    if (!RST) begin
      REQ_ACK       <= '0;
      TX_IN_V       <= 1'b0;
      TX_IN_P       <= '0;
      parity_enable <= 1'b0;
      parity_type   <= 1'b0;
      GRANT_ID      <= '0;
      SCHED_BUSY    <= 1'b0;
      START_TIMEOUT <= 1'b0;
    end else begin
      TX_IN_V       <= grant_s;
      SCHED_BUSY    <= (state_nxt_s != IDLE);
      START_TIMEOUT <= timeout_s;
      if (grant_s) begin
        REQ_ACK       <= NUM_REQ'(1) << win_idx_s;
        TX_IN_P       <= REQ_DATA[win_idx_s*DATA_WIDTH +: DATA_WIDTH];
        parity_enable <= REQ_PAR_EN[win_idx_s];
        parity_type   <= REQ_PAR_TYP[win_idx_s];
        GRANT_ID      <= win_idx_s;
      end else begin
        REQ_ACK       <= '0;
        TX_IN_P       <= TX_IN_P;
        parity_enable <= parity_enable;
        parity_type   <= parity_type;
        GRANT_ID      <= GRANT_ID;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;
  localparam int DW  = 8;
  localparam int NR  = 4;
  localparam int STO = 16;

  logic              TX_CLK = 1'b0;
  logic              RST    = 1'b0;
  logic [NR-1:0]     REQ_V       = '0;
  logic [NR*DW-1:0]  REQ_DATA    = '0;
  logic [NR-1:0]     REQ_PAR_EN  = '0;
  logic [NR-1:0]     REQ_PAR_TYP = '0;
  logic [NR-1:0]     REQ_ACK;
  logic [DW-1:0]     TX_IN_P;
  logic              TX_IN_V;
  logic              TX_OUT_V = 1'b0;
  logic              parity_enable;
  logic              parity_type;
  logic [1:0]        GRANT_ID;
  logic              SCHED_BUSY;
  logic              START_TIMEOUT;

  uart_tx_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .START_TO(STO)) dut (
    .TX_CLK(TX_CLK), .RST(RST), .REQ_V(REQ_V), .REQ_DATA(REQ_DATA),
    .REQ_PAR_EN(REQ_PAR_EN), .REQ_PAR_TYP(REQ_PAR_TYP), .REQ_ACK(REQ_ACK),
    .TX_IN_P(TX_IN_P), .TX_IN_V(TX_IN_V), .TX_OUT_V(TX_OUT_V),
    .parity_enable(parity_enable), .parity_type(parity_type), .GRANT_ID(GRANT_ID),
    .SCHED_BUSY(SCHED_BUSY), .START_TIMEOUT(START_TIMEOUT)
  );

  initial forever #5 TX_CLK = ~TX_CLK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_no   = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge TX_CLK);
    cyc_no++;
  end

  // Reference model: one outstanding frame at a time, tracked as "owned / launched / started".
  bit          m_active = 1'b0, m_launch = 1'b0, m_started = 1'b0;
  int          m_wait = 0, m_ptr = 0;
  logic [NR-1:0] ex_ack = '0;
  logic [DW-1:0] ex_p = '0;
  logic        ex_v = 1'b0, ex_pe = 1'b0, ex_pt = 1'b0, ex_busy = 1'b0, ex_to = 1'b0;
  logic [1:0]  ex_gid = '0;

  initial forever begin
    @(posedge TX_CLK or negedge RST);
    if (RST !== 1'b1) begin
      m_active = 1'b0; m_launch = 1'b0; m_started = 1'b0; m_wait = 0; m_ptr = 0;
      ex_ack = '0; ex_p = '0; ex_v = 1'b0; ex_pe = 1'b0; ex_pt = 1'b0;
      ex_busy = 1'b0; ex_to = 1'b0; ex_gid = '0;
    end else begin
      ex_v = 1'b0; ex_ack = '0; ex_to = 1'b0;
      if (!m_active) begin
        if (REQ_V != '0) begin
          int w;
          w = -1;
          for (int i = 0; i < NR; i++)
            if (w < 0 && REQ_V[(m_ptr + i) % NR]) w = (m_ptr + i) % NR;
          ex_gid = 2'(w);
          ex_p   = REQ_DATA[w*DW +: DW];
          ex_pe  = REQ_PAR_EN[w];
          ex_pt  = REQ_PAR_TYP[w];
          ex_ack = NR'(1) << w;
          ex_v   = 1'b1;
          m_active = 1'b1; m_launch = 1'b1; m_started = 1'b0; m_wait = 0;
        end
      end else if (m_launch) begin
        m_launch = 1'b0;
      end else if (!m_started) begin
        if (TX_OUT_V) m_started = 1'b1;
        else begin
          m_wait++;
          if (m_wait == STO) begin
            m_active = 1'b0; ex_to = 1'b1; m_ptr = (int'(ex_gid) + 1) % NR;
          end
        end
      end else if (!TX_OUT_V) begin
        m_active = 1'b0; m_ptr = (int'(ex_gid) + 1) % NR;
      end
      ex_busy = m_active;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge TX_CLK);
    if (cmp_en) begin
      chk("m_REQ_ACK", 32'(REQ_ACK), 32'(ex_ack));
      chk("m_TX_IN_V", 32'(TX_IN_V), 32'(ex_v));
      chk("m_TX_IN_P", 32'(TX_IN_P), 32'(ex_p));
      chk("m_par_en", 32'(parity_enable), 32'(ex_pe));
      chk("m_par_typ", 32'(parity_type), 32'(ex_pt));
      chk("m_GRANT_ID", 32'(GRANT_ID), 32'(ex_gid));
      chk("m_SCHED_BUSY", 32'(SCHED_BUSY), 32'(ex_busy));
      chk("m_START_TIMEOUT", 32'(START_TIMEOUT), 32'(ex_to));
    end
  end

  // Transmitter emulation: TX_OUT_V high from start_dly to start_dly+frame_len-1 cycles after launch.
  bit tx_en = 1'b1;
  bit glitch_req = 1'b0;
  int start_dly = 2;
  int frame_len = 10;
  int t = -1;

  initial forever begin
    @(posedge TX_CLK);
    #2;
    if (TX_IN_V === 1'b1 && tx_en) t = 0;
    else if (t >= 0) t = t + 1;
    if (t >= start_dly + frame_len) t = -1;
    if (glitch_req && t < 0) begin
      TX_OUT_V = 1'b1;
      glitch_req = 1'b0;
    end else begin
      TX_OUT_V = (t >= 0) && (t >= start_dly);
    end
  end

  task automatic step();
    @(posedge TX_CLK);
    #3;
  endtask

  task automatic wait_launch(input int max);
    int n = 0;
    while (TX_IN_V !== 1'b1 && n < max) begin step(); n++; end
    chk("launch_seen", 32'(TX_IN_V), 32'd1);
  endtask

  task automatic wait_txo(input logic lvl, input int max);
    int n = 0;
    while (TX_OUT_V !== lvl && n < max) begin step(); n++; end
    chk("tx_out_v_level", 32'(TX_OUT_V), 32'(lvl));
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (SCHED_BUSY !== 1'b0 && n < max) begin step(); n++; end
    chk("back_to_idle", 32'(SCHED_BUSY), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_gid[5]        = '{0, 1, 2, 3, 0};
    logic [7:0] exp_b[5]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    logic [3:0] exp_a[5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic exp_pe[5]       = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int last;
    int n;

    cmp_en = 1'b1;
    repeat (2) step();
    chk("rst_REQ_ACK", 32'(REQ_ACK), 32'd0);
    chk("rst_TX_IN_V", 32'(TX_IN_V), 32'd0);
    chk("rst_TX_IN_P", 32'(TX_IN_P), 32'd0);
    chk("rst_GRANT_ID", 32'(GRANT_ID), 32'd0);
    chk("rst_SCHED_BUSY", 32'(SCHED_BUSY), 32'd0);
    chk("rst_par", 32'({parity_enable, parity_type, START_TIMEOUT}), 32'd0);
    RST = 1'b1;
    repeat (2) step();

    // Fairness: all requesters held high, 10-cycle frames, 2-cycle start delay.
    REQ_DATA = {8'h44, 8'h33, 8'h22, 8'h11};
    REQ_PAR_EN = 4'b1010;
    REQ_PAR_TYP = 4'b0110;
    start_dly = 2; frame_len = 10;
    REQ_V = 4'b1111;
    last = 0;
    for (int g = 0; g < 5; g++) begin
      wait_launch(40);
      chk("rr_grant", 32'(GRANT_ID), 32'(exp_gid[g]));
      chk("rr_ack", 32'(REQ_ACK), 32'(exp_a[g]));
      chk("rr_byte", 32'(TX_IN_P), 32'(exp_b[g]));
      chk("rr_par_en", 32'(parity_enable), 32'(exp_pe[g]));
      if (g > 0) chk("rr_spacing", 32'(cyc_no - last), 32'd14);
      last = cyc_no;
      if (g == 4) REQ_V = 4'b0000;
      step();
    end
    wait_idle(40);

    // Single request from requester 2; pointer now at 1.
    REQ_DATA[23:16] = 8'hA5;
    REQ_PAR_EN = 4'b0100;
    REQ_PAR_TYP = 4'b0100;
    frame_len = 11;
    REQ_V = 4'b0100;
    step();
    chk("single_latency", 32'(TX_IN_V), 32'd1);
    chk("single_ack", 32'(REQ_ACK), 32'b0100);
    chk("single_byte", 32'(TX_IN_P), 32'hA5);
    chk("single_par", 32'({parity_enable, parity_type}), 32'b11);
    chk("single_grant", 32'(GRANT_ID), 32'd2);
    REQ_V = 4'b0000;
    wait_txo(1'b1, 10);
    wait_txo(1'b0, 20);
    chk("busy_at_fall", 32'(SCHED_BUSY), 32'd1);
    step();
    chk("busy_after_fall", 32'(SCHED_BUSY), 32'd0);
    chk("byte_held_idle", 32'(TX_IN_P), 32'hA5);

    // Config isolation: requester 1 (search from 3 wraps to 1), edited during the frame.
    REQ_DATA[15:8] = 8'h3C;
    REQ_PAR_EN = 4'b0000;
    REQ_PAR_TYP = 4'b0000;
    REQ_V = 4'b0010;
    wait_launch(10);
    chk("iso_grant", 32'(GRANT_ID), 32'd1);
    REQ_V = 4'b0000;
    wait_txo(1'b1, 10);
    REQ_DATA[15:8] = 8'hFF;
    REQ_PAR_TYP = 4'b0010;
    repeat (2) step();
    chk("iso_byte_busy", 32'(TX_IN_P), 32'h3C);
    chk("iso_typ_busy", 32'(parity_type), 32'd0);
    wait_idle(30);
    step();
    chk("iso_byte_idle", 32'(TX_IN_P), 32'h3C);
    chk("iso_typ_idle", 32'(parity_type), 32'd0);
    glitch_req = 1'b1;
    repeat (3) step();
    chk("glitch_ignored", 32'(SCHED_BUSY), 32'd0);

    // Start timeout: transmitter never starts; requester 3 granted from pointer 2.
    tx_en = 1'b0;
    REQ_V = 4'b1000;
    wait_launch(10);
    chk("to_grant", 32'(GRANT_ID), 32'd3);
    REQ_V = 4'b0000;
    n = 0;
    while (START_TIMEOUT !== 1'b1 && n < 40) begin step(); n++; end
    chk("to_cycles", 32'(n), 32'd17);
    chk("to_idle", 32'(SCHED_BUSY), 32'd0);
    tx_en = 1'b1;
    REQ_V = 4'b1001;
    step();
    chk("to_pulse_width", 32'(START_TIMEOUT), 32'd0);
    chk("to_next_launch", 32'(TX_IN_V), 32'd1);
    chk("to_next_grant", 32'(GRANT_ID), 32'd0);
    REQ_V = 4'b0000;

    // Reset mid-frame, then grant order restarts from index 0.
    wait_txo(1'b1, 10);
    repeat (2) step();
    #1 RST = 1'b0;
    #1;
    chk("arst_TX_IN_P", 32'(TX_IN_P), 32'd0);
    chk("arst_GRANT_ID", 32'(GRANT_ID), 32'd0);
    chk("arst_busy", 32'(SCHED_BUSY), 32'd0);
    chk("arst_par_en", 32'(parity_enable), 32'd0);
    REQ_V = 4'b1001;
    repeat (2) step();
    RST = 1'b1;
    wait_launch(10);
    chk("post_rst_grant", 32'(GRANT_ID), 32'd0);
    chk("post_rst_ack", 32'(REQ_ACK), 32'b0001);
    REQ_V = 4'b0000;
    wait_idle(40);
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one UART transmitter among NUM_REQ requesters (e.g. host FIFO, status reporter, loopback echo) using round-robin arbitration.
- Per frame: latches the winner's byte and parity configuration, launches the frame with a one-cycle TX_IN_V strobe, and holds the config stable until the transmitter deasserts TX_OUT_V.
- Start timeout recovers from a transmitter that never starts.
- Sits between the requester logic and the UART TX datapath, in the TX_CLK domain.

Parameters:
- DATA_WIDTH, 8, frame payload width.
- NUM_REQ, 4, number of requesters (2..8).
- START_TO, 16, max cycles in WAIT_START before timeout.

Ports:
- TX_CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- REQ_V  input  NUM_REQ  per-requester valid; held until the matching REQ_ACK.
- REQ_DATA  input  NUM_REQ*DATA_WIDTH  packed bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- REQ_PAR_EN  input  NUM_REQ  per-requester parity enable.
- REQ_PAR_TYP  input  NUM_REQ  per-requester parity type (0 even, 1 odd).
- REQ_ACK  output  NUM_REQ  one-hot, one-cycle pulse when a request is accepted.
- TX_IN_P  output  DATA_WIDTH  byte to the transmitter.
- TX_IN_V  output  1  one-cycle launch strobe.
- TX_OUT_V  input  1  transmitter busy, high for the whole frame.
- parity_enable  output  1  parity config to the transmitter.
- parity_type  output  1  parity config to the transmitter.
- GRANT_ID  output  $clog2(NUM_REQ)  index of the current or last winner.
- SCHED_BUSY  output  1  high in any state except IDLE.
- START_TIMEOUT  output  1  one-cycle pulse on timeout.

Behaviour:
- Reset (RST low, asynchronous): state IDLE; all outputs 0; rr pointer 0; latched data and config 0.
- States: IDLE, LOAD, WAIT_START, WAIT_END.
- IDLE:
  - No REQ_V bit set: remain in IDLE.
  - Any REQ_V bit set: winner = first set bit searching upward, with wrap, from (last_winner+1) mod NUM_REQ.
  - At that edge: register winner's REQ_DATA into TX_IN_P, REQ_PAR_EN into parity_enable, REQ_PAR_TYP into parity_type, and the index into GRANT_ID. Move to LOAD.
- LOAD (exactly 1 cycle): TX_IN_V=1; REQ_ACK[winner]=1; then go to WAIT_START.
  - Latency: REQ_V seen in IDLE -> TX_IN_V and REQ_ACK both high on the next cycle.
- WAIT_START:
  - Wait for TX_OUT_V=1, then go to WAIT_END.
  - Counter counts cycles in this state. If it reaches START_TO with TX_OUT_V still 0: pulse START_TIMEOUT for 1 cycle and return to IDLE. The request counts as consumed (already ACKed). The rr pointer still advances.
- WAIT_END: wait for TX_OUT_V=0, then go to IDLE and set last_winner=GRANT_ID.
  - Back-to-back: the earliest next TX_IN_V is 2 cycles after TX_OUT_V falls (IDLE, then LOAD).
- TX_IN_P, parity_enable, parity_type, GRANT_ID hold stable from LOAD through WAIT_END, and also in IDLE until the next grant. Changes to REQ_* after acceptance have no effect.
- TX_IN_V is never asserted outside LOAD; at most one REQ_ACK bit is ever high.
- TX_OUT_V already 1 on entering WAIT_START: go to WAIT_END the next cycle (counter unused).
- TX_OUT_V glitching high while in IDLE: ignored.
- REQ_V bit dropping before ACK: protocol violation; the scheduler does not check it. Arbitration uses the value sampled in IDLE.
- Fairness: with all REQ_V held high, grant order is 0,1,...,NUM_REQ-1,0,...
- RST asserted mid-frame: immediate return to reset values; the in-flight request is not ACKed again. The next grant starts searching from index 0.

Test Plan:
- Single request: REQ_V=4'b0100, REQ_DATA[23:16]=8'hA5, PAR_EN[2]=1, PAR_TYP[2]=1; TX_OUT_V high 2 cycles after launch for 11 cycles -> next cycle TX_IN_V=1, REQ_ACK=4'b0100, TX_IN_P=A5, parity 1/1, GRANT_ID=2; SCHED_BUSY drops 1 cycle after TX_OUT_V falls.
- All four REQ_V held high, each frame 10 busy cycles -> grants 0,1,2,3,0; REQ_ACK is one-hot in every case; TX_IN_V spacing = frame length + 2 turnaround cycles + start delay.
- Config isolation: change REQ_DATA and REQ_PAR_TYP of the winner during WAIT_END -> TX_IN_P and parity_type are unchanged until the next grant.
- Timeout: TX_OUT_V stuck 0, START_TO=16 -> START_TIMEOUT pulses 16 cycles after entering WAIT_START, state IDLE, and the next request is from the following index.
- Reset mid-frame: drop RST during WAIT_END -> all outputs 0 asynchronously; after release with REQ_V=4'b1001, requester 0 is granted first.
